// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared state encoding and helpers for the PLL reset sequencer
package pll_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - lock input, debug controls and reset/status outputs of the sequencer
interface pll_reset_sequencer_if
  import pll_pkg::*;
#(
  parameter int LOSS_CNT_W = 8
);

  logic                  locked;
  logic                  clear_lost;
  logic                  sys_rst_n;
  logic                  ready;
  logic                  lock_lost;
  logic [LOSS_CNT_W-1:0] loss_count;
  logic [STATE_W-1:0]    fsm_state;

  // Side that drives the PLL lock flag and consumes the system reset.
  modport master (
    output locked,
    output clear_lost,
    input  sys_rst_n,
    input  ready,
    input  lock_lost,
    input  loss_count,
    input  fsm_state
  );

  // The sequencer itself.
  modport slave (
    input  locked,
    input  clear_lost,
    output sys_rst_n,
    output ready,
    output lock_lost,
    output loss_count,
    output fsm_state
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_bit.sv
// rtl/pll_reset_sequencer_sync_bit.sv - multi-flop single-bit synchronizer with async active-low clear
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain; cleared so a fresh lock must re-propagate after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - debounces PLL lock, times the reset hold and tracks lock losses
module pll_reset_sequencer
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES        = 32,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  pll_reset_sequencer_if.slave bus
);

  localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic                  lock_s;
  logic                  loss_evt;
  pll_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sys_rst_n_q, sys_rst_n_d;
  logic                  ready_q, ready_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clkin),
    .rst_n(rst_n),
    .d    (bus.locked),
    .q    (lock_s)
  );

  // Next state, phase counter and registered outputs; any drop of lock_s returns to WAIT_LOCK.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss_evt     = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = CNT_ONE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_TERM) begin
          state_d = HOLD;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_TERM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Reset release and ready are registered on the same edge that enters RUN.
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);

    loss_count_d = loss_count_q;
    if (loss_evt && (loss_count_q != {LOSS_CNT_W{1'b1}})) begin
      loss_count_d = loss_count_q + LOSS_CNT_W'(1);
    end

    // A loss on the same edge as a clear keeps the flag set.
    if (loss_evt) begin
      lock_lost_d = 1'b1;
    end else if (bus.clear_lost) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end
  end

  // State, counter and output registers; board reset forces everything to the safe values.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_rst_n_q  <= sys_rst_n_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.ready      = ready_q;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.loss_count = loss_count_q;
  assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed-vector bench for the PLL reset sequencer
module tb_pll_reset_sequencer;

  localparam int S    = 2;
  localparam int L    = 4;
  localparam int H    = 8;
  localparam int W    = 2;
  localparam int RISE = S + L + H + 1;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clkin = ~clkin;

  pll_reset_sequencer_if #(.LOSS_CNT_W(W)) bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES       (S),
    .LOCK_STABLE_CYCLES(L),
    .HOLD_CYCLES       (H),
    .LOSS_CNT_W        (W)
  ) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  function automatic int exp_state(input int e);
    if (e <= S) return 0;
    if (e <= S + L) return 1;
    if (e <= S + L + H) return 2;
    return 3;
  endfunction

  task automatic run_lockup(input string tag, input int st_from);
    bus.locked = 1'b1;
    for (int e = 1; e <= RISE; e++) begin
      step();
      chk({tag, "_sys_rst_n"}, 32'(bus.sys_rst_n), 32'(e >= RISE));
      chk({tag, "_ready"}, 32'(bus.ready), 32'(e >= RISE));
      if (e >= st_from) chk({tag, "_state"}, 32'(bus.fsm_state), 32'(exp_state(e)));
    end
    step();
    chk({tag, "_run_hold"}, 32'(bus.sys_rst_n), 32'd1);
  endtask

  task automatic lose(input string tag, input int exp_cnt, input logic with_clear);
    bus.locked = 1'b0;
    step();
    chk({tag, "_k_rst"}, 32'(bus.sys_rst_n), 32'd1);
    step();
    chk({tag, "_k1_ready"}, 32'(bus.ready), 32'd1);
    bus.clear_lost = with_clear;
    step();
    bus.clear_lost = 1'b0;
    chk({tag, "_k2_rst"}, 32'(bus.sys_rst_n), 32'd0);
    chk({tag, "_k2_ready"}, 32'(bus.ready), 32'd0);
    chk({tag, "_lock_lost"}, 32'(bus.lock_lost), 32'd1);
    chk({tag, "_loss_count"}, 32'(bus.loss_count), 32'(exp_cnt));
    chk({tag, "_state"}, 32'(bus.fsm_state), 32'd0);
  endtask

  initial begin
    bus.locked     = 1'b0;
    bus.clear_lost = 1'b0;
    repeat (3) step();
    chk("rst_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("rst_loss_count", 32'(bus.loss_count), 32'd0);
    chk("rst_state", 32'(bus.fsm_state), 32'd0);

    // Lock-up from a clean release.
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_state", 32'(bus.fsm_state), 32'd0);
    run_lockup("t1", 1);

    // Glitch during debounce restarts the sequence.
    lose("t2pre", 1, 1'b0);
    bus.locked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_glitch_rst", 32'(bus.sys_rst_n), 32'd0);
    end
    bus.locked = 1'b0;
    step();
    chk("t2_glitch_low", 32'(bus.sys_rst_n), 32'd0);
    run_lockup("t2", 2);

    // Remaining RUN-state losses, saturating at 3.
    lose("t4_l3", 2, 1'b0);
    run_lockup("t4r3", 1);
    lose("t4_l4", 3, 1'b0);
    run_lockup("t4r4", 1);
    lose("t4_l5", 3, 1'b0);
    run_lockup("t4r5", 1);

    // Clear coincident with a loss loses; clear alone wins.
    lose("t5_set", 3, 1'b1);
    run_lockup("t5r", 1);
    bus.clear_lost = 1'b1;
    step();
    bus.clear_lost = 1'b0;
    chk("t5_clr_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("t5_clr_loss_count", 32'(bus.loss_count), 32'd3);

    // Asynchronous reset mid-HOLD.
    lose("t6_pre", 3, 1'b0);
    bus.locked = 1'b1;
    repeat (9) step();
    chk("t6_in_hold", 32'(bus.fsm_state), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("t6h_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    chk("t6h_loss_count", 32'(bus.loss_count), 32'd0);
    chk("t6h_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("t6h_state", 32'(bus.fsm_state), 32'd0);
    rst_n = 1'b1;
    run_lockup("t6h", 1);

    // Asynchronous reset mid-RUN after a counted loss.
    lose("t6_pre2", 1, 1'b0);
    run_lockup("t6p", 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6r_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    chk("t6r_ready", 32'(bus.ready), 32'd0);
    chk("t6r_loss_count", 32'(bus.loss_count), 32'd0);
    chk("t6r_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("t6r_state", 32'(bus.fsm_state), 32'd0);
    rst_n = 1'b1;
    run_lockup("t6r", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
